xor_bus_arbiter: RTL and testbench
==================================

Name: xor_bus_arbiter

Overview:
- Shares one multi-bit XOR datapath (operand invert + bitwise XOR) between NR_OF_REQ requesters in the prototype processor.
- Round-robin arbitration, operand capture, registered result with tag, and ready/valid backpressure to the consumer.
- Per-request invert bits configure the operand inversion dynamically, replacing a fixed per-instance invert mask.
- Sits between ALU-side requesters (flag logic, checksum unit, compare path) and a single shared XOR resource.

Parameters:
- NR_OF_BITS, 8, operand/result width; legal range 1..32.
- NR_OF_REQ, 4, number of requesters; legal range 2..8.
- TAG_BITS, 2, width of Result_Tag; must equal clog2(NR_OF_REQ).

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  reset; synchronous, active-low.
- Req  in  NR_OF_REQ  per-requester request level.
- Req_Operand_1  in  NR_OF_REQ*NR_OF_BITS  operand 1 lanes; requester i uses slice [i*NR_OF_BITS +: NR_OF_BITS].
- Req_Operand_2  in  NR_OF_REQ*NR_OF_BITS  operand 2 lanes; same slicing.
- Req_Invert  in  2*NR_OF_REQ  per-requester invert bits; bit 2i inverts operand 1, bit 2i+1 inverts operand 2.
- Grant  out  NR_OF_REQ  one-hot, single-cycle acknowledge that requester's operands were captured.
- Result  out  NR_OF_BITS  registered XOR result.
- Result_Tag  out  TAG_BITS  index of the requester that owns Result.
- Result_Valid  out  1  Result and Result_Tag are valid.
- Result_Ready  in  1  consumer accepts Result when high together with Result_Valid.
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (Reset_n=0 at an edge):
  - State goes to IDLE and the priority pointer to 0.
  - Grant, Result, Result_Tag, Result_Valid and Busy all go to 0.
  - Reset mid-operation aborts the operation: captured operands are discarded and no Grant or Result_Valid is produced afterwards.
- FSM states are IDLE, EXEC and HOLD.
- IDLE:
  - If Req is nonzero at edge t, select the winner: the first set Req bit at or after the pointer, searching upward and wrapping modulo NR_OF_REQ.
  - At the same edge, capture the winner's operands, invert bits and index, and set Grant[winner]=1.
  - Set pointer = (winner+1) mod NR_OF_REQ and move to EXEC.
  - If Req is zero, remain in IDLE.
- EXEC:
  - Grant returns to 0 (it is exactly one cycle wide).
  - At edge t+1: Result = (op1 ^ {NR_OF_BITS{inv1}}) XOR (op2 ^ {NR_OF_BITS{inv2}}).
  - Also at edge t+1: Result_Tag = captured index, Result_Valid=1, move to HOLD.
- HOLD:
  - Result, Result_Tag and Result_Valid stay stable while Result_Ready=0.
  - At an edge with Result_Ready=1: Result_Valid goes to 0 and the FSM returns to IDLE.
  - Result and Result_Tag keep their last value after the handshake.
- Latency and throughput:
  - Req sampled at edge t produces Grant visible in cycle t+1 and Result_Valid in cycle t+2.
  - Peak throughput is 1 operation per 3 cycles.
- Requester contract:
  - Hold Req, operands and invert bits stable until Grant is seen.
  - Deassert Req in the cycle Grant is seen, otherwise a second operation is issued.
  - Req dropped before being sampled is simply not served.
- Requests arriving during EXEC or HOLD are not sampled; they wait for IDLE. Round-robin order guarantees no starvation.
- Result_Ready while Result_Valid=0 is ignored.
- Only one operation is in flight; there is no queue.
- Busy = (state != IDLE).

Decomposition:
- Shared package (xor_arb_pkg):
  - FSM state encodings: IDLE=2'd0, EXEC=2'd1, HOLD=2'd2.
  - A constant clog2 function used to derive and check TAG_BITS.
- One natural sub-module, rr_priority_picker:
  - Combinational; inputs Req and pointer.
  - Outputs a one-hot winner, the winner index and an any-request flag.
- The invert+XOR expression stays inline in xor_bus_arbiter.

Test Plan:
- Single request:
  - Stimulus: NR_OF_BITS=8; Req=4'b0010, op1=8'hA5, op2=8'h0F, inv=2'b00, Result_Ready=1.
  - Response: Grant=4'b0010 in cycle t+1; Result=8'hAA, Tag=1, Valid in cycle t+2; Busy low from t+3.
- Round-robin fairness:
  - Stimulus: all four requesters hold Req high; each drops Req after its Grant, then re-asserts it.
  - Response: Grant order 0,1,2,3,0; no requester is granted twice before the others are granted.
- Invert bits:
  - Stimulus: op1=8'h3C, op2=8'h3C; run with inv=2'b01, then 2'b11, then 2'b00.
  - Response: Result=8'hFF, then 8'h00, then 8'h00.
- Backpressure:
  - Stimulus: Result_Ready=0 for 5 cycles after Valid rises, while Req=4'b0001 is pending.
  - Response: Result, Tag and Valid stay constant; no new Grant until the cycle after Ready=1 is accepted.
- Reset mid-operation:
  - Stimulus: Reset_n=0 during EXEC.
  - Response: next cycle all outputs are 0 and the pointer is 0; Valid never rises for the aborted operation.
- Width edge case:
  - Stimulus: NR_OF_BITS=1, NR_OF_REQ=2; op1=1, op2=1, inv=2'b10.
  - Response: Result=1'b1, Tag=0.

Source files
------------

// File: rtl/xor_arb_pkg.sv
// Shared definitions for the XOR bus arbiter: FSM encodings and a constant log2 helper.
// No logic; no latency. No backpressure.
package xor_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Minimum index width for n items; returns 0 for n <= 1.
    function automatic int clog2_c(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request at or above ptr, wrapping modulo NR_OF_REQ.
// Purely combinational, zero latency.
// No backpressure; the caller decides when to act on the winner.
module rr_priority_picker #(
    parameter int NR_OF_REQ = 4,
    parameter int IDX_BITS  = 2
) (
    input  logic [NR_OF_REQ-1:0] req,
    input  logic [IDX_BITS-1:0]  ptr,
    output logic [NR_OF_REQ-1:0] winner_oh,
    output logic [IDX_BITS-1:0]  winner_idx,
    output logic                 any_req
);

    always_comb begin : pick
        int j;
        j          = 0;
        winner_oh  = '0;
        winner_idx = '0;
        any_req    = 1'b0;
        for (int k = 0; k < NR_OF_REQ; k++) begin
            j = (int'(ptr) + k) % NR_OF_REQ;
            if (!any_req && req[j]) begin
                any_req       = 1'b1;
                winner_oh[j]  = 1'b1;
                winner_idx    = IDX_BITS'(j);
            end
        end
    end

endmodule

// File: rtl/xor_bus_arbiter.sv
// Shares one invert+XOR datapath among NR_OF_REQ requesters with round-robin arbitration.
// Grant one cycle after Req is sampled, Result_Valid one cycle later; one op per 3 cycles.
// Result held stable until Result_Ready; new requests are only sampled in IDLE.
module xor_bus_arbiter
    import xor_arb_pkg::*;
#(
    parameter int NR_OF_BITS = 8,
    parameter int NR_OF_REQ  = 4,
    parameter int TAG_BITS   = 2
) (
    input  logic                            Clock,
    input  logic                            Reset_n,
    input  logic [NR_OF_REQ-1:0]            Req,
    input  logic [NR_OF_REQ*NR_OF_BITS-1:0] Req_Operand_1,
    input  logic [NR_OF_REQ*NR_OF_BITS-1:0] Req_Operand_2,
    input  logic [2*NR_OF_REQ-1:0]          Req_Invert,
    output logic [NR_OF_REQ-1:0]            Grant,
    output logic [NR_OF_BITS-1:0]           Result,
    output logic [TAG_BITS-1:0]             Result_Tag,
    output logic                            Result_Valid,
    input  logic                            Result_Ready,
    output logic                            Busy
);

    if (TAG_BITS != clog2_c(NR_OF_REQ)) begin : g_tag_check
        $error("xor_bus_arbiter: TAG_BITS must equal clog2(NR_OF_REQ)");
    end

    state_e                  state_q, state_d;
    logic [TAG_BITS-1:0]     ptr_q, ptr_d;
    logic [NR_OF_BITS-1:0]   op1_q, op1_d;
    logic [NR_OF_BITS-1:0]   op2_q, op2_d;
    logic [1:0]              inv_q, inv_d;
    logic [TAG_BITS-1:0]     idx_q, idx_d;
    logic [NR_OF_REQ-1:0]    grant_q, grant_d;
    logic [NR_OF_BITS-1:0]   result_q, result_d;
    logic [TAG_BITS-1:0]     tag_q, tag_d;
    logic                    valid_q, valid_d;

    logic [NR_OF_REQ-1:0]    win_oh;
    logic [TAG_BITS-1:0]     win_idx;
    logic                    any_req;

    rr_priority_picker #(
        .NR_OF_REQ (NR_OF_REQ),
        .IDX_BITS  (TAG_BITS)
    ) u_picker (
        .req        (Req),
        .ptr        (ptr_q),
        .winner_oh  (win_oh),
        .winner_idx (win_idx),
        .any_req    (any_req)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        inv_d    = inv_q;
        idx_d    = idx_q;
        grant_d  = '0;
        result_d = result_q;
        tag_d    = tag_q;
        valid_d  = valid_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    op1_d   = Req_Operand_1[int'(win_idx)*NR_OF_BITS +: NR_OF_BITS];
                    op2_d   = Req_Operand_2[int'(win_idx)*NR_OF_BITS +: NR_OF_BITS];
                    inv_d   = Req_Invert[2*int'(win_idx) +: 2];
                    idx_d   = win_idx;
                    grant_d = win_oh;
                    ptr_d   = (int'(win_idx) == NR_OF_REQ-1) ? '0 : win_idx + 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = (op1_q ^ {NR_OF_BITS{inv_q[0]}}) ^ (op2_q ^ {NR_OF_BITS{inv_q[1]}});
                tag_d    = idx_q;
                valid_d  = 1'b1;
                state_d  = HOLD;
            end
            HOLD: begin
                // Result and tag deliberately survive the handshake.
                if (Result_Ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            inv_q    <= '0;
            idx_q    <= '0;
            grant_q  <= '0;
            result_q <= '0;
            tag_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            inv_q    <= inv_d;
            idx_q    <= idx_d;
            grant_q  <= grant_d;
            result_q <= result_d;
            tag_q    <= tag_d;
            valid_q  <= valid_d;
        end
    end

    assign Grant        = grant_q;
    assign Result       = result_q;
    assign Result_Tag   = tag_q;
    assign Result_Valid = valid_q;
    assign Busy         = (state_q != IDLE);

endmodule

// File: tb/tb_xor_bus_arbiter.sv
// Self-checking bench for xor_bus_arbiter: vector table, hand sequences, randomized ops vs model.
// Inputs driven and outputs sampled on the falling clock edge.
// Exercises Result_Ready backpressure with pending requests.
module tb_xor_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_op1, req_op2;
    logic [7:0]  req_inv;
    logic [3:0]  grant;
    logic [7:0]  result;
    logic [1:0]  tag;
    logic        valid, busy;
    logic        ready = 1'b0;

    logic [7:0]  l_op1 [4];
    logic [7:0]  l_op2 [4];
    logic [1:0]  l_inv [4];

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign req_op1[g*8 +: 8] = l_op1[g];
        assign req_op2[g*8 +: 8] = l_op2[g];
        assign req_inv[g*2 +: 2] = l_inv[g];
    end

    // Narrow instance: 1-bit operands, two requesters.
    logic [1:0] w_req = '0, w_op1 = '0, w_op2 = '0, w_grant;
    logic [3:0] w_inv = '0;
    logic [0:0] w_result, w_tag;
    logic       w_valid, w_busy;

    always #5 clk = ~clk;

    xor_bus_arbiter #(.NR_OF_BITS(8), .NR_OF_REQ(4), .TAG_BITS(2)) dut (
        .Clock(clk), .Reset_n(rst_n), .Req(req),
        .Req_Operand_1(req_op1), .Req_Operand_2(req_op2), .Req_Invert(req_inv),
        .Grant(grant), .Result(result), .Result_Tag(tag), .Result_Valid(valid),
        .Result_Ready(ready), .Busy(busy)
    );

    xor_bus_arbiter #(.NR_OF_BITS(1), .NR_OF_REQ(2), .TAG_BITS(1)) dut_w (
        .Clock(clk), .Reset_n(rst_n), .Req(w_req),
        .Req_Operand_1(w_op1), .Req_Operand_2(w_op2), .Req_Invert(w_inv),
        .Grant(w_grant), .Result(w_result), .Result_Tag(w_tag), .Result_Valid(w_valid),
        .Result_Ready(1'b1), .Busy(w_busy)
    );

    int total = 0;
    int bad   = 0;
    int m_ptr = 0;

    typedef struct {
        logic [3:0] req;
        logic [7:0] op1;
        logic [7:0] op2;
        logic [1:0] inv;
        int         delay;
        int         exp_w;
        logic [7:0] exp_res;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: rotate through requesters starting at the pointer.
    function automatic int m_pick(input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [7:0] m_res(input int w);
        logic [7:0] a, b;
        a = l_inv[w][0] ? ~l_op1[w] : l_op1[w];
        b = l_inv[w][1] ? ~l_op2[w] : l_op2[w];
        return a ^ b;
    endfunction

    task automatic set_lanes(input logic [7:0] a, input logic [7:0] b, input logic [1:0] i);
        for (int k = 0; k < 4; k++) begin
            l_op1[k] = a;
            l_op2[k] = b;
            l_inv[k] = i;
        end
    endtask

    // Called at a falling edge with the DUT idle and req already set.
    task automatic serve_one(input int exp_w, input logic [7:0] exp_res, input int delay,
                             input logic [3:0] pend);
        logic [3:0] oh;
        oh = 4'b0001 << exp_w;
        ready = (delay == 0);
        @(negedge clk);
        chk("grant", {28'd0, grant}, {28'd0, oh});
        chk("busy_exec", {31'd0, busy}, 32'd1);
        chk("valid_exec", {31'd0, valid}, 32'd0);
        req[exp_w] = 1'b0;
        req = req | pend;
        m_ptr = (exp_w + 1) % 4;
        @(negedge clk);
        chk("grant_pulse", {28'd0, grant}, 32'd0);
        chk("valid", {31'd0, valid}, 32'd1);
        chk("result", {24'd0, result}, {24'd0, exp_res});
        chk("tag", {30'd0, tag}, exp_w);
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, valid}, 32'd1);
            chk("hold_result", {24'd0, result}, {24'd0, exp_res});
            chk("hold_tag", {30'd0, tag}, exp_w);
            chk("hold_nogrant", {28'd0, grant}, 32'd0);
            if (d == delay - 1) ready = 1'b1;
        end
        @(negedge clk);
        chk("valid_drop", {31'd0, valid}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("result_kept", {24'd0, result}, {24'd0, exp_res});
        chk("nogrant_hs", {28'd0, grant}, 32'd0);
    endtask

    vec_t vecs [8];
    int   fair [5];
    int   w;

    initial begin
        vecs[0] = '{4'b0010, 8'hA5, 8'h0F, 2'b00, 0, 1, 8'hAA};
        vecs[1] = '{4'b0001, 8'h3C, 8'h3C, 2'b01, 0, 0, 8'hFF};
        vecs[2] = '{4'b0001, 8'h3C, 8'h3C, 2'b11, 1, 0, 8'h00};
        vecs[3] = '{4'b0001, 8'h3C, 8'h3C, 2'b00, 0, 0, 8'h00};
        vecs[4] = '{4'b1001, 8'h12, 8'h34, 2'b10, 0, 3, 8'hD9};
        vecs[5] = '{4'b1001, 8'hFF, 8'h00, 2'b00, 2, 0, 8'hFF};
        vecs[6] = '{4'b0110, 8'h5A, 8'hA5, 2'b11, 0, 1, 8'hFF};
        vecs[7] = '{4'b0100, 8'h80, 8'h01, 2'b00, 5, 2, 8'h81};
        fair = '{0, 1, 2, 3, 0};
        set_lanes(8'h00, 8'h00, 2'b00);

        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_tag", {30'd0, tag}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        m_ptr = 0;

        // 1-bit / 2-requester instance.
        w_req = 2'b01; w_op1 = 2'b01; w_op2 = 2'b01; w_inv = 4'b0010;
        @(negedge clk);
        chk("w_grant0", {30'd0, w_grant}, 32'd1);
        w_req = 2'b00;
        @(negedge clk);
        chk("w_valid0", {31'd0, w_valid}, 32'd1);
        chk("w_result0", {31'd0, w_result}, 32'd1);
        chk("w_tag0", {31'd0, w_tag}, 32'd0);
        @(negedge clk);
        chk("w_drop0", {31'd0, w_valid}, 32'd0);
        w_req = 2'b11; w_op1 = 2'b11; w_op2 = 2'b11; w_inv = 4'b0000;
        @(negedge clk);
        chk("w_grant1", {30'd0, w_grant}, 32'd2);
        w_req = 2'b00;
        @(negedge clk);
        chk("w_result1", {31'd0, w_result}, 32'd0);
        chk("w_tag1", {31'd0, w_tag}, 32'd1);
        @(negedge clk);
        chk("w_busy1", {31'd0, w_busy}, 32'd0);

        // Vector table.
        for (int i = 0; i < 8; i++) begin
            req = vecs[i].req;
            set_lanes(vecs[i].op1, vecs[i].op2, vecs[i].inv);
            serve_one(vecs[i].exp_w, vecs[i].exp_res, vecs[i].delay, 4'b0000);
        end
        req = '0;

        // Reset during EXEC aborts the operation and clears the pointer.
        set_lanes(8'h11, 8'h22, 2'b00);
        req = 4'b0001;
        ready = 1'b1;
        @(negedge clk);
        chk("abort_grant", {28'd0, grant}, 32'd1);
        rst_n = 1'b0;
        req = '0;
        @(negedge clk);
        chk("abort_grant0", {28'd0, grant}, 32'd0);
        chk("abort_result", {24'd0, result}, 32'd0);
        chk("abort_tag", {30'd0, tag}, 32'd0);
        chk("abort_valid", {31'd0, valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        m_ptr = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_novalid", {31'd0, valid}, 32'd0);
            chk("abort_nogrant", {28'd0, grant}, 32'd0);
        end

        // Fairness with all requesters persistently asserting.
        for (int k = 0; k < 4; k++) begin
            l_op1[k] = 8'(16 * k + 3);
            l_op2[k] = 8'(k * 7);
            l_inv[k] = 2'(k);
        end
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            serve_one(fair[i], m_res(fair[i]), 0, 4'b0000);
            req = 4'b1111;
        end
        req = '0;

        // Backpressure with requester 0 pending during HOLD.
        req = 4'b0010;
        serve_one(1, m_res(1), 5, 4'b0001);
        serve_one(0, m_res(0), 0, 4'b0000);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            req = 4'($urandom_range(1, 15));
            for (int k = 0; k < 4; k++) begin
                l_op1[k] = 8'($urandom);
                l_op2[k] = 8'($urandom);
                l_inv[k] = 2'($urandom);
            end
            w = m_pick(req);
            serve_one(w, m_res(w), int'($urandom_range(0, 3)), 4'b0000);
        end
        req = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
